// File: rtl/lcd_id_pkg.sv
// Shared types and strap decode table for the LCD panel-ID sequencer.
// Combinational helpers only; no state.
// No flow control; consumers sample the decode result directly.
package lcd_id_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    // Pixel-rate selection driven on div_sel
    localparam logic [1:0] DIV_OFF = 2'd0;
    localparam logic [1:0] DIV_1   = 2'd1;
    localparam logic [1:0] DIV_2   = 2'd2;
    localparam logic [1:0] DIV_4   = 2'd3;

    // Panel IDs and the {M2,M1,M0} strap codes that select them
    localparam logic [15:0] ID_4342 = 16'h4342;
    localparam logic [15:0] ID_7084 = 16'h7084;
    localparam logic [15:0] ID_7016 = 16'h7016;
    localparam logic [15:0] ID_4384 = 16'h4384;
    localparam logic [15:0] ID_1018 = 16'h1018;

    localparam logic [2:0] CODE_4342 = 3'b000;
    localparam logic [2:0] CODE_7084 = 3'b001;
    localparam logic [2:0] CODE_7016 = 3'b010;
    localparam logic [2:0] CODE_4384 = 3'b100;
    localparam logic [2:0] CODE_1018 = 3'b101;

    typedef struct packed {
        logic        valid;
        logic [15:0] id;
        logic [1:0]  div_sel;
    } decode_t;

    // Strap code to {valid, panel id, pixel divider}; unknown codes decode invalid
    function automatic decode_t lcd_decode(input logic [2:0] code);
        decode_t r;
        r = '{valid: 1'b0, id: 16'h0000, div_sel: DIV_OFF};
        case (code)
            CODE_4342: r = '{valid: 1'b1, id: ID_4342, div_sel: DIV_4};
            CODE_7084: r = '{valid: 1'b1, id: ID_7084, div_sel: DIV_2};
            CODE_7016: r = '{valid: 1'b1, id: ID_7016, div_sel: DIV_1};
            CODE_4384: r = '{valid: 1'b1, id: ID_4384, div_sel: DIV_2};
            CODE_1018: r = '{valid: 1'b1, id: ID_1018, div_sel: DIV_1};
            default:   r = '{valid: 1'b0, id: 16'h0000, div_sel: DIV_OFF};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pclk_en_gen.sv
// Pixel clock enable generator: /1, /2 or /4 strobe while the panel is running.
// Registered output; run/div_sel are next-cycle values so pclk_en lines up with them.
// No backpressure; the strobe free-runs while run is high.
module pclk_en_gen
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] div_sel,
    output logic       pclk_en
);
    import lcd_id_pkg::*;

    logic [1:0] pc_q, pc_d;
    logic       pclk_en_q, pclk_en_d;

    // pc_q is the DONE-cycle index the next registered strobe belongs to;
    // it sits at 0 whenever run is low, so every DONE entry starts at pc = 0
    always_comb begin
        pc_d      = run ? pc_q + 2'd1 : 2'd0;
        pclk_en_d = 1'b0;
        case (div_sel)
            DIV_1:   pclk_en_d = run;
            DIV_2:   pclk_en_d = run & pc_q[0];
            DIV_4:   pclk_en_d = run & (pc_q == 2'd3);
            default: pclk_en_d = 1'b0;
        endcase
    end

    // Counter and strobe registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q      <= 2'd0;
            pclk_en_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pclk_en_q <= pclk_en_d;
        end
    end

    assign pclk_en = pclk_en_q;

endmodule

// File: rtl/lcd_id_ctrl.sv
// Power-up LCD sequencer: settle straps, triple-sample, decode panel ID, enable pixel clock.
// Detection pass takes SETTLE_CYC + 2*SAMPLE_GAP + 2 cycles from SETTLE entry; all outputs registered.
// No backpressure; rescan is honoured only in DONE or ERR and ignored elsewhere.
module lcd_id_ctrl
#(
    parameter int SETTLE_CYC = 50000,
    parameter int SAMPLE_GAP = 16,
    parameter int MAX_RETRY  = 3
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_pins,
    input  logic        rescan,
    output logic        rgb_oe,
    output logic [15:0] lcd_id,
    output logic        id_valid,
    output logic        id_err,
    output logic [1:0]  div_sel,
    output logic        pclk_en,
    output logic        disp_en
);
    import lcd_id_pkg::*;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic [2:0]  sync_q, ids_q;
    logic [2:0]  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
    decode_t     dec;

    logic        rgb_oe_q, rgb_oe_d;
    logic [15:0] lcd_id_q, lcd_id_d;
    logic        id_valid_q, id_valid_d;
    logic        id_err_q, id_err_d;
    logic [1:0]  div_sel_q, div_sel_d;
    logic        disp_en_q, disp_en_d;

    // All three samples are equal whenever this is used, so s0 alone decides
    assign dec = lcd_decode(s0_q);

    // State, 2-FF strap synchronizer and sequencing datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET;
            cnt_q   <= 32'd0;
            retry_q <= 8'd0;
            sync_q  <= 3'b000;
            ids_q   <= 3'b000;
            s0_q    <= 3'b000;
            s1_q    <= 3'b000;
            s2_q    <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            sync_q  <= id_pins;
            ids_q   <= sync_q;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    // Next state: settle timer, three spaced samples, consistency check, retry
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_SETTLE;
                cnt_d   = 32'd0;
            end
            ST_SETTLE: begin
                if (cnt_q == 32'(SETTLE_CYC - 1)) begin
                    state_d = ST_SAMPLE;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_SAMPLE: begin
                if (cnt_q == 32'd0)
                    s0_d = ids_q;
                if (cnt_q == 32'(SAMPLE_GAP))
                    s1_d = ids_q;
                if (cnt_q == 32'(2 * SAMPLE_GAP)) begin
                    s2_d    = ids_q;
                    state_d = ST_CHECK;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_CHECK: begin
                if ((s0_q == s1_q) && (s1_q == s2_q)) begin
                    state_d = dec.valid ? ST_DONE : ST_ERR;
                end else begin
                    // Saturates: reaching MAX_RETRY always lands in ERR
                    if (retry_q != 8'(MAX_RETRY))
                        retry_d = retry_q + 8'd1;
                    state_d = (retry_q + 8'd1 == 8'(MAX_RETRY)) ? ST_ERR : ST_SETTLE;
                end
            end
            ST_DONE, ST_ERR: begin
                if (rescan) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 32'd0;
                    retry_d = 8'd0;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // Output next values follow state_d so each registered output matches its state
    always_comb begin
        rgb_oe_d   = (state_d == ST_DONE);
        disp_en_d  = (state_d == ST_DONE);
        id_valid_d = (state_d == ST_DONE);
        id_err_d   = (state_d == ST_ERR);
        lcd_id_d   = 16'h0000;
        div_sel_d  = DIV_OFF;
        if (state_d == ST_DONE) begin
            if (state_q == ST_CHECK) begin
                lcd_id_d  = dec.id;
                div_sel_d = dec.div_sel;
            end else begin
                lcd_id_d  = lcd_id_q;
                div_sel_d = div_sel_q;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_oe_q   <= 1'b0;
            lcd_id_q   <= 16'h0000;
            id_valid_q <= 1'b0;
            id_err_q   <= 1'b0;
            div_sel_q  <= DIV_OFF;
            disp_en_q  <= 1'b0;
        end else begin
            rgb_oe_q   <= rgb_oe_d;
            lcd_id_q   <= lcd_id_d;
            id_valid_q <= id_valid_d;
            id_err_q   <= id_err_d;
            div_sel_q  <= div_sel_d;
            disp_en_q  <= disp_en_d;
        end
    end

    pclk_en_gen u_pclk_en_gen (
        .clk     (clk),
        .rst     (rst),
        .run     (state_d == ST_DONE),
        .div_sel (div_sel_d),
        .pclk_en (pclk_en)
    );

    assign rgb_oe   = rgb_oe_q;
    assign lcd_id   = lcd_id_q;
    assign id_valid = id_valid_q;
    assign id_err   = id_err_q;
    assign div_sel  = div_sel_q;
    assign disp_en  = disp_en_q;

endmodule

// File: tb/tb_lcd_id_ctrl.sv
// Bench for lcd_id_ctrl with short settle/gap so full passes fit in a few hundred cycles.
// Completion results go through a scoreboard; cycle timing checked inline.
// Inputs driven and outputs sampled on the falling edge.
module tb_lcd_id_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  id_pins;
    logic        rescan;
    logic        rgb_oe;
    logic [15:0] lcd_id;
    logic        id_valid;
    logic        id_err;
    logic [1:0]  div_sel;
    logic        pclk_en;
    logic        disp_en;

    typedef struct {
        logic        valid;
        logic        err;
        logic [15:0] id;
        logic [1:0]  div;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    lcd_id_ctrl #(
        .SETTLE_CYC (8),
        .SAMPLE_GAP (2),
        .MAX_RETRY  (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .id_pins  (id_pins),
        .rescan   (rescan),
        .rgb_oe   (rgb_oe),
        .lcd_id   (lcd_id),
        .id_valid (id_valid),
        .id_err   (id_err),
        .div_sel  (div_sel),
        .pclk_en  (pclk_en),
        .disp_en  (disp_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_rescan();
        rescan = 1'b1;
        tick(1);
        rescan = 1'b0;
    endtask

    function automatic logic [2:0] tog(input int k);
        logic [2:0] v;
        case (k % 3)
            0:       v = 3'b000;
            1:       v = 3'b001;
            default: v = 3'b010;
        endcase
        return v;
    endfunction

    function automatic exp_t mk(input logic v, input logic e, input logic [15:0] id, input logic [1:0] d);
        exp_t r;
        r.valid = v;
        r.err   = e;
        r.id    = id;
        r.div   = d;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rgb_oe"},   32'(rgb_oe),   32'd0);
        chk({tag, "_lcd_id"},   32'(lcd_id),   32'd0);
        chk({tag, "_id_valid"}, 32'(id_valid), 32'd0);
        chk({tag, "_id_err"},   32'(id_err),   32'd0);
        chk({tag, "_div_sel"},  32'(div_sel),  32'd0);
        chk({tag, "_pclk_en"},  32'(pclk_en),  32'd0);
        chk({tag, "_disp_en"},  32'(disp_en),  32'd0);
    endtask

    // Scoreboard: each completion (rise of id_valid or id_err) pops one expectation
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((id_valid || id_err) && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", sb.size(), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("sb_valid",  32'(id_valid), 32'(e.valid));
                    chk("sb_err",    32'(id_err),   32'(e.err));
                    chk("sb_lcd_id", 32'(lcd_id),   32'(e.id));
                    chk("sb_div",    32'(div_sel),  32'(e.div));
                end
            end
            done_prev = id_valid || id_err;
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        id_pins = 3'b000;
        rescan  = 1'b0;
        tick(3);
        chk_all_zero("reset");

        // 000 from reset: DONE 14 cycles after SETTLE entry, /4 strobe
        sb.push_back(mk(1'b1, 1'b0, 16'h4342, 2'd3));
        rst = 1'b0;
        tick(1);
        tick(13);
        chk("s000_not_early", 32'(id_valid), 32'd0);
        tick(1);
        chk("s000_valid", 32'(id_valid), 32'd1);
        chk("s000_id", 32'(lcd_id), 32'h4342);
        chk("s000_rgb_oe", 32'(rgb_oe), 32'd1);
        chk("s000_disp_en", 32'(disp_en), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("s000_pclk_div4", 32'(pclk_en), 32'(k % 4 == 3));
            tick(1);
        end

        // 010 via rescan: outputs clear next cycle, then /1 continuous
        id_pins = 3'b010;
        pulse_rescan();
        chk_all_zero("rescan_clr");
        sb.push_back(mk(1'b1, 1'b0, 16'h7016, 2'd1));
        tick(14);
        chk("s010_div", 32'(div_sel), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("s010_pclk_div1", 32'(pclk_en), 32'd1);
            chk("s010_rgb_oe", 32'(rgb_oe), 32'd1);
            tick(1);
        end

        // 001 with a rescan pulse during SETTLE that must be ignored
        id_pins = 3'b001;
        pulse_rescan();
        sb.push_back(mk(1'b1, 1'b0, 16'h7084, 2'd2));
        tick(5);
        pulse_rescan();
        tick(8);
        chk("rescan_ignored_done", 32'(id_valid), 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("s001_pclk_div2", 32'(pclk_en), 32'(k % 2 == 1));
            tick(1);
        end

        // 001 -> 101 rescan
        id_pins = 3'b101;
        pulse_rescan();
        chk("s101_clr_id", 32'(lcd_id), 32'd0);
        chk("s101_clr_valid", 32'(id_valid), 32'd0);
        sb.push_back(mk(1'b1, 1'b0, 16'h1018, 2'd1));
        tick(14);
        chk("s101_id", 32'(lcd_id), 32'h1018);

        // 111 is invalid: ERR after one pass with everything else low
        id_pins = 3'b111;
        pulse_rescan();
        sb.push_back(mk(1'b0, 1'b1, 16'h0000, 2'd0));
        tick(14);
        for (int k = 0; k < 4; k++) begin
            chk("s111_err", 32'(id_err), 32'd1);
            chk("s111_pclk", 32'(pclk_en), 32'd0);
            chk("s111_disp", 32'(disp_en), 32'd0);
            chk("s111_rgb_oe", 32'(rgb_oe), 32'd0);
            chk("s111_id", 32'(lcd_id), 32'd0);
            tick(1);
        end

        // Straps changing every cycle: three mismatched passes, then ERR
        id_pins = tog(0);
        pulse_rescan();
        sb.push_back(mk(1'b0, 1'b1, 16'h0000, 2'd0));
        for (int k = 1; k <= 41; k++) begin
            id_pins = tog(k);
            tick(1);
        end
        chk("retry_err_not_early", 32'(id_err), 32'd0);
        tick(1);
        chk("retry_err", 32'(id_err), 32'd1);

        // One mismatched pass, then stable 101: DONE after the second pass
        id_pins = tog(0);
        pulse_rescan();
        sb.push_back(mk(1'b1, 1'b0, 16'h1018, 2'd1));
        for (int k = 1; k <= 13; k++) begin
            id_pins = tog(k);
            tick(1);
        end
        id_pins = 3'b101;
        tick(14);
        chk("retry1_not_early", 32'(id_valid), 32'd0);
        tick(1);
        chk("retry1_valid", 32'(id_valid), 32'd1);
        chk("retry1_id", 32'(lcd_id), 32'h1018);
        chk("retry1_pclk", 32'(pclk_en), 32'd1);

        // Asynchronous reset in DONE
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("arst_done");
        id_pins = 3'b100;
        tick(3);
        rst = 1'b0;

        // Asynchronous reset mid-SAMPLE, then a clean pass after release
        tick(11);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("arst_sample");
        tick(2);
        sb.push_back(mk(1'b1, 1'b0, 16'h4384, 2'd2));
        rst = 1'b0;
        tick(14);
        chk("restart_not_early", 32'(id_valid), 32'd0);
        tick(1);
        chk("restart_valid", 32'(id_valid), 32'd1);
        chk("restart_id", 32'(lcd_id), 32'h4384);
        for (int k = 0; k < 4; k++) begin
            chk("s100_pclk_div2", 32'(pclk_en), 32'(k % 2 == 1));
            tick(1);
        end

        tick(2);
        chk("sb_drain", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
